mul_div_unit: RTL and testbench

- Multi-cycle integer multiply/divide unit sitting directly upstream of the Hi/Lo register.
- Takes two 32-bit operands plus an opcode and computes a 64-bit result iteratively, one bit per cycle.
- Presents the result on mutiAns as {Hi, Lo}: {high, low} for multiply, {remainder, quotient} for divide.
- Issues a one-cycle done pulse when the value on mutiAns is ready for the Hi/Lo register to capture.

---
 rtl/mdu_pkg.sv | 6 +
 rtl/mul_div_unit_if.sv | 13 +
 rtl/mdu_sign_fix.sv | 8 +
 rtl/mul_div_unit.sv | 98 +++++++++
 tb/tb_mul_div_unit.sv | 116 +++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op/state encodings and default width for the multiply/divide unit
package mdu_pkg;
  localparam int WIDTH = 32;
  typedef enum logic [1:0] {OP_MULTU = 2'b00, OP_MULT = 2'b01, OP_DIVU = 2'b10, OP_DIV = 2'b11} opT;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} stateT;
endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/result bundle between the issuing stage and the multiply/divide unit
interface mul_div_unit_if #(parameter int WIDTH = mdu_pkg::WIDTH);
  logic start;
  logic [1:0] op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic busy;
  logic done;
  logic div_zero;
  logic [2*WIDTH-1:0] mutiAns;
  modport master(output start, op, src_a, src_b, input busy, done, div_zero, mutiAns);
  modport slave(input start, op, src_a, src_b, output busy, done, div_zero, mutiAns);
endinterface

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: conditional two's-complement negate, used for magnitudes and result correction
module mdu_sign_fix #(parameter int N = 32) (
  input  logic [N-1:0] x,
  input  logic         neg,
  output logic [N-1:0] y
);
  assign y = neg ? -x : x;
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative one-bit-per-cycle multiply/divide feeding the Hi/Lo register
module mul_div_unit import mdu_pkg::*; #(parameter int WIDTH = mdu_pkg::WIDTH) (
  input logic clk,
  input logic reset,
  mul_div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  stateT state;
  logic isDiv, signA, signB, busy, done, divZero;
  logic [WIDTH-1:0] aMag, bMag, rawA;
  logic [2*WIDTH:0] acc;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] mutiAns;
  logic inIsDiv, inSigned, inSignA, inSignB;
  logic [WIDTH-1:0] inAbsA, inAbsB, quotFix, remFix;
  logic [2*WIDTH-1:0] prodFix;
  logic [WIDTH:0] sum, shRem, diff;
  logic borrow;
  logic [2*WIDTH:0] mulNext, divNext;

  assign inIsDiv  = bus.op == OP_DIVU || bus.op == OP_DIV;
  assign inSigned = bus.op == OP_MULT || bus.op == OP_DIV;
  assign inSignA  = inSigned & bus.src_a[WIDTH-1];
  assign inSignB  = inSigned & bus.src_b[WIDTH-1];

  mdu_sign_fix #(.N(WIDTH)) absA (.x(bus.src_a), .neg(inSignA), .y(inAbsA));
  mdu_sign_fix #(.N(WIDTH)) absB (.x(bus.src_b), .neg(inSignB), .y(inAbsB));
  mdu_sign_fix #(.N(2*WIDTH)) fixProd (.x(acc[2*WIDTH-1:0]), .neg(signA ^ signB), .y(prodFix));
  mdu_sign_fix #(.N(WIDTH)) fixQuot (.x(acc[WIDTH-1:0]), .neg(signA ^ signB), .y(quotFix));
  mdu_sign_fix #(.N(WIDTH)) fixRem (.x(acc[2*WIDTH-1:WIDTH]), .neg(signA), .y(remFix));

  // one iteration step: shift-add multiply and restoring divide on the shared accumulator
  always_comb begin
    sum     = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, aMag} : '0);
    mulNext = {1'b0, sum, acc[WIDTH-1:1]};
    shRem   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = shRem - {1'b0, bMag};
    borrow  = diff[WIDTH];
    divNext = {1'b0, borrow ? shRem[WIDTH-1:0] : diff[WIDTH-1:0], acc[WIDTH-2:0], ~borrow};
  end

  // control FSM and datapath registers; outputs are registered here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      isDiv   <= 1'b0;
      signA   <= 1'b0;
      signB   <= 1'b0;
      aMag    <= '0;
      bMag    <= '0;
      rawA    <= '0;
      acc     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      divZero <= 1'b0;
      mutiAns <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          isDiv   <= inIsDiv;
          signA   <= inSignA;
          signB   <= inSignB;
          aMag    <= inAbsA;
          bMag    <= inAbsB;
          rawA    <= bus.src_a;
          acc     <= {1'b0, {WIDTH{1'b0}}, inIsDiv ? inAbsA : inAbsB};
          cnt     <= '0;
          busy    <= 1'b1;
          divZero <= 1'b0;
          state   <= S_CALC;
        end
        S_CALC: begin
          acc   <= isDiv ? divNext : mulNext;
          cnt   <= cnt + CW'(1);
          state <= cnt == CW'(WIDTH - 1) ? S_FIX : S_CALC;
        end
        S_FIX: begin
          mutiAns <= !isDiv ? prodFix : bMag == '0 ? {rawA, {WIDTH{1'b1}}} : {remFix, quotFix};
          divZero <= isDiv && bMag == '0;
          busy    <= 1'b0;
          done    <= 1'b1;
          state   <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.div_zero = divZero;
  assign bus.mutiAns  = mutiAns;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vector table plus abort/ignored-start sequences for mul_div_unit
module tb_mul_div_unit;
  import mdu_pkg::*;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mul_div_unit_if bus ();
  mul_div_unit dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] ans;
    logic        dz;
  } vecT;
  vecT vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] ans, input logic dz, input string name, input int glitch);
    int lat = -1;
    logic busyOk = 1'b1;
    int extra = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.op = ~op; bus.src_a = ~a; bus.src_b = b + 32'd1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n == 0) chk({name, " dzclr"}, 64'(bus.div_zero), 64'd0);
      if (bus.done) begin
        lat = n;
        break;
      end
      if (!bus.busy) busyOk = 1'b0;
      if (glitch != 0 && n == glitch) begin
        bus.start = 1'b1; bus.op = OP_DIVU; bus.src_a = 32'd9; bus.src_b = 32'd0;
      end
      if (glitch != 0 && n == glitch + 1) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    chk({name, " latency"}, 64'(lat), 64'd33);
    chk({name, " busy"}, 64'(busyOk), 64'd1);
    chk({name, " ans"}, bus.mutiAns, ans);
    chk({name, " dz"}, 64'(bus.div_zero), 64'(dz));
    chk({name, " busylow"}, 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk({name, " pulse"}, 64'(bus.done), 64'd0);
    if (glitch != 0) begin
      repeat (40) begin
        @(negedge clk);
        if (bus.done || bus.busy) extra++;
      end
      chk({name, " noqueue"}, 64'(extra), 64'd0);
      chk({name, " held"}, bus.mutiAns, ans);
    end
  endtask

  initial begin
    vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 1'b0};
    vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        64'hFFFFFFFF_FFFFFFF1, 1'b0};
    vecs[2]  = '{OP_MULT,  32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0};
    vecs[3]  = '{OP_DIVU,  32'd100,      32'd7,        64'h00000002_0000000E, 1'b0};
    vecs[4]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 1'b0};
    vecs[5]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 1'b0};
    vecs[6]  = '{OP_DIVU,  32'd5,        32'd0,        64'h00000005_FFFFFFFF, 1'b1};
    vecs[7]  = '{OP_MULTU, 32'd2,        32'd3,        64'h00000000_00000006, 1'b0};
    vecs[8]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0};
    vecs[9]  = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        64'hFFFFFFFB_FFFFFFFF, 1'b1};
    vecs[10] = '{OP_MULT,  32'd7,        32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFF9, 1'b0};
    vecs[11] = '{OP_DIVU,  32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, 1'b0};

    bus.start = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst done", 64'(bus.done), 64'd0);
    chk("rst dz", 64'(bus.div_zero), 64'd0);
    chk("rst ans", bus.mutiAns, 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ans, vecs[i].dz, $sformatf("vec%0d", i), 0);

    runOp(OP_MULTU, 32'h1234, 32'h10, 64'h00000000_00012340, 1'b0, "ignored", 5);

    runOp(OP_DIVU, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1'b1, "predz", 0);
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIVU; bus.src_a = 32'hFFFF; bus.src_b = 32'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort busy", 64'(bus.busy), 64'd0);
    chk("abort done", 64'(bus.done), 64'd0);
    chk("abort dz", 64'(bus.div_zero), 64'd0);
    chk("abort ans", bus.mutiAns, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    runOp(OP_DIVU, 32'd9, 32'd3, 64'h00000000_00000003, 1'b0, "after", 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
